// File: rtl/lmc_pkg.sv
// Shared types and default widths for the LMC RAM loader and its address counter.
package lmc_pkg;

  localparam int unsigned LMC_N = 2;
  localparam int unsigned LMC_M = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } lmc_state_e;

endpackage

// File: rtl/lmc_adr_counter.sv
// W-bit address counter with synchronous clear, increment enable and
// terminal-count flag; clear takes priority over increment.
module lmc_adr_counter #(
  parameter int unsigned W = lmc_pkg::LMC_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/lmc_ram_loader.sv
// Fills the write-enable-less LMC RAM from a word stream (LOAD) or streams it out
// in address order (SCAN); recirculates ram_out whenever no new word is written.
module lmc_ram_loader
  import lmc_pkg::*;
#(
  parameter int unsigned N = LMC_N,
  parameter int unsigned M = LMC_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_load,
  input  logic         start_scan,
  input  logic         in_valid,
  input  logic [M-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [M-1:0] out_data,
  input  logic         out_ready,
  output logic [N-1:0] adr,
  output logic [M-1:0] data_in,
  input  logic [M-1:0] ram_out,
  output logic         busy,
  output logic         done
);

  lmc_state_e state_q;
  lmc_state_e state_d;

  logic         cnt_clr;
  logic         cnt_inc;
  logic         cnt_tc;
  logic [N-1:0] cnt;

  lmc_adr_counter #(
    .W (N)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control and handshake/status decode.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
        end else if (start_scan) begin
          state_d = ST_SCAN;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (cnt_tc) begin
            state_d = ST_DONE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          if (cnt_tc) begin
            state_d = ST_DONE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only an accepted load word replaces the RAM's own value; reset forces IDLE,
  // so recirculation also covers the reset period.
  assign data_in  = (state_q == ST_LOAD && in_valid) ? in_data : ram_out;
  assign out_data = ram_out;
  assign adr      = cnt;

endmodule

// File: tb/tb_lmc_ram_loader.sv
// Bench for lmc_ram_loader with a behavioural RAM, a reference memory image and
// a scoreboard of expected scan words checked by an independent monitor.
module tb_lmc_ram_loader;

  localparam int unsigned N     = 2;
  localparam int unsigned M     = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         start_load;
  logic         start_scan;
  logic         in_valid;
  logic [M-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [M-1:0] out_data;
  logic         out_ready;
  logic [N-1:0] adr;
  logic [M-1:0] data_in;
  logic [M-1:0] ram_out;
  logic         busy;
  logic         done;

  logic [M-1:0] ram     [DEPTH];
  logic [M-1:0] ref_mem [DEPTH];
  logic [M-1:0] exp_q   [$];

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int exp_done  = 0;

  lmc_ram_loader #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_scan (start_scan),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .adr        (adr),
    .data_in    (data_in),
    .ram_out    (ram_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LMC RAM stage: writes data_in every edge, asynchronous read.
  always @(posedge clk) ram[adr] <= data_in;
  assign ram_out = ram[adr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each taken scan word must match the queue head; a
  // stalled word must already equal the head and stay there.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("scan_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else if (out_ready) begin
        check("scan_word", 32'(out_data), 32'(exp_q.pop_front()));
      end else begin
        check("scan_stall_word", 32'(out_data), 32'(exp_q[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < int'(DEPTH); i++)
      check($sformatf("%s_mem%0d", tag, i), 32'(ram[i]), 32'(ref_mem[i]));
  endtask

  // Load four words; stall_n cycles of in_valid=0 precede word index stall_at.
  task automatic do_load(input logic [M-1:0] w0, input logic [M-1:0] w1,
                         input logic [M-1:0] w2, input logic [M-1:0] w3,
                         input int stall_at, input int stall_n, input bit scan_too);
    logic [M-1:0] w [DEPTH];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    start_load = 1'b1;
    start_scan = scan_too;
    tick();
    start_load = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          in_valid = 1'b0;
          in_data  = M'($urandom);
          @(negedge clk);
          check("load_stall_ready", 32'(in_ready), 32'd1);
          check("load_stall_adr", 32'(adr), 32'(i));
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
      check("load_ready", 32'(in_ready), 32'd1);
      check("load_busy", 32'(busy), 32'd1);
      check("load_out_valid", 32'(out_valid), 32'd0);
      check("load_adr", 32'(adr), 32'(i));
      tick();
    end
    in_valid = 1'b0;
    in_data  = M'($urandom);
    @(negedge clk);
    check("load_done", 32'(done), 32'd1);
    check("load_done_busy", 32'(busy), 32'd0);
    check("load_done_ready", 32'(in_ready), 32'd0);
    exp_done++;
    tick();
    start_scan = 1'b0;
    @(negedge clk);
    check("load_idle_done", 32'(done), 32'd0);
    check("load_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = w[i];
    tick();
  endtask

  // Scan with an out_ready pattern (bit k drives cycle k, then 1s).  With b2b,
  // start_scan is driven during DONE and the following IDLE cycle, leaving the
  // DUT already in SCAN for a following call with pre_started set.
  task automatic do_scan(input logic [15:0] pat, input int plen, input bit pre_started,
                         input bit b2b);
    int hs;
    int k;
    if (!pre_started) begin
      start_scan = 1'b1;
      out_ready  = 1'b0;
      tick();
      start_scan = 1'b0;
    end
    for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back(ref_mem[i]);
    hs = 0;
    k  = 0;
    while (hs < int'(DEPTH) && k < plen + 16) begin
      out_ready = (k < plen) ? pat[k] : 1'b1;
      @(negedge clk);
      if (k == 0) check("scan_first_adr", 32'(adr), 32'd0);
      check("scan_valid", 32'(out_valid), 32'd1);
      check("scan_busy", 32'(busy), 32'd1);
      check("scan_in_ready", 32'(in_ready), 32'd0);
      if (out_ready) hs++;
      tick();
      k++;
    end
    if (hs < int'(DEPTH)) check("scan_timeout", 32'(hs), 32'(DEPTH));
    out_ready  = 1'b0;
    start_scan = b2b;
    @(negedge clk);
    check("scan_done", 32'(done), 32'd1);
    check("scan_done_valid", 32'(out_valid), 32'd0);
    check("scan_done_busy", 32'(busy), 32'd0);
    exp_done++;
    tick();
    @(negedge clk);
    check("scan_idle_valid", 32'(out_valid), 32'd0);
    check("scan_idle_done", 32'(done), 32'd0);
    tick();
    start_scan = 1'b0;
    check("scan_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start_load = 1'b0;
    start_scan = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_in", 32'(data_in), 32'(ram_out));
    rst = 1'b0;
    tick();

    // Load with a two-cycle gap before the third word.
    do_load(4'hA, 4'h5, 4'h3, 4'hF, 2, 2, 1'b0);
    check_mem("load");

    // IDLE must not disturb the RAM even with valid words offered.
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = M'($urandom);
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_data_in", 32'(data_in), 32'(ram_out));
      tick();
    end
    in_valid = 1'b0;
    check_mem("idle");

    // Backpressured scan, then a back-to-back restart.
    do_scan(16'b0000_0000_0101_1001, 7, 1'b0, 1'b1);
    do_scan(16'($urandom), 10, 1'b1, 1'b0);

    // Simultaneous starts: LOAD wins; start_scan held through LOAD is ignored.
    do_load(M'($urandom), M'($urandom), M'($urandom), M'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    check_mem("sim");
    do_scan(16'($urandom), 12, 1'b0, 1'b0);

    // Reset asserted between edges with cnt=2 and a word on the bus.
    do_load(4'hA, 4'h5, 4'h3, 4'hF, 0, 0, 1'b0);
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    in_valid   = 1'b1;
    in_data    = 4'h1;
    tick();
    in_data = 4'h2;
    tick();
    in_data = 4'h9;
    @(negedge clk);
    check("pre_rst_adr", 32'(adr), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_adr", 32'(adr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_data_in", 32'(data_in), 32'(ram_out));
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    ref_mem[0] = 4'h1;
    ref_mem[1] = 4'h2;
    tick();
    check_mem("rst");
    do_scan(16'($urandom), 12, 1'b0, 1'b0);

    // Random load/scan rounds.
    for (int r = 0; r < 3; r++) begin
      do_load(M'($urandom), M'($urandom), M'($urandom), M'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      check_mem("rand");
      do_scan(16'($urandom), 12, 1'b0, 1'b0);
    end

    repeat (2) tick();
    check("done_pulse_count", 32'(done_seen), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
